// File: rtl/seq_comparator.sv
// Digit-serial magnitude comparator: DIGIT bits per cycle, MSB-first, optional early exit.
// Latency 1..WIDTH/DIGIT cycles after capture; start is ignored while busy, accepted in the done cycle.
module seq_comparator #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             ls,
    output logic             eq
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dec_vld;
    logic               r_dec_gt;
    logic               r_done;
    logic               r_gt;
    logic               r_ls;
    logic               r_eq;

    logic [DIGIT-1:0]   w_dig_a;
    logic [DIGIT-1:0]   w_dig_b;
    logic               w_diff;
    logic               w_last;
    logic               w_capture;
    logic               w_decide;
    logic               w_res_gt;
    logic               w_res_ls;
    logic [WIDTH-1:0]   w_a_cap;
    logic [WIDTH-1:0]   w_b_cap;

    assign w_dig_a = r_a[WIDTH-1 -: DIGIT];
    assign w_dig_b = r_b[WIDTH-1 -: DIGIT];
    assign w_diff  = (w_dig_a != w_dig_b);
    assign w_last  = (r_cnt == CNT_W'(1));

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_a_cap = signed_mode ? (a ^ MSB_MASK) : a;
    assign w_b_cap = signed_mode ? (b ^ MSB_MASK) : b;

    // A latched decision (only possible without early exit) overrides later digits.
    assign w_res_gt = r_dec_vld ? r_dec_gt  : (w_diff && (w_dig_a > w_dig_b));
    assign w_res_ls = r_dec_vld ? !r_dec_gt : (w_diff && (w_dig_a < w_dig_b));

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_decide    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last || ((EARLY_EXIT != 0) && w_diff && !r_dec_vld)) begin
                    w_decide    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_dec_vld <= 1'b0;
            r_dec_gt  <= 1'b0;
            r_done    <= 1'b0;
            r_gt      <= 1'b0;
            r_ls      <= 1'b0;
            r_eq      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_a       <= w_a_cap;
                r_b       <= w_b_cap;
                r_cnt     <= CNT_W'(NUM_DIGITS);
                r_dec_vld <= 1'b0;
                r_dec_gt  <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_a   <= r_a << DIGIT;
                r_b   <= r_b << DIGIT;
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_diff && !r_dec_vld) begin
                    r_dec_vld <= 1'b1;
                    r_dec_gt  <= (w_dig_a > w_dig_b);
                end
                if (w_decide) begin
                    r_done <= 1'b1;
                    r_gt   <= w_res_gt;
                    r_ls   <= w_res_ls;
                    r_eq   <= !w_res_gt && !w_res_ls;
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign gt   = r_gt;
    assign ls   = r_ls;
    assign eq   = r_eq;

endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: one early-exit and one full-length instance, scoreboard of {result, done cycle}.
module tb_seq_comparator;

    typedef struct {
        string  name;
        logic   gt;
        logic   ls;
        logic   eq;
        int     cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start0 = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy1, done1, gt1, ls1, eq1;
    logic       busy0, done0, gt0, ls0, eq0;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q1[$];
    exp_t q0[$];

    seq_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u_dut_ee (
        .clk(clk), .rst(rst), .start(start1), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy1), .done(done1), .gt(gt1), .ls(ls1), .eq(eq1)
    );

    seq_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u_dut_full (
        .clk(clk), .rst(rst), .start(start0), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy0), .done(done0), .gt(gt0), .ls(ls0), .eq(eq0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Early-exit instance: every done pulse must match the oldest expectation, on the expected cycle.
    always @(posedge clk) begin
        #1;
        if (done1) begin
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL ee_unexpected_done cyc=%0d got gt/ls/eq=%b%b%b required no done", cyc, gt1, ls1, eq1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if ({gt1, ls1, eq1} !== {e.gt, e.ls, e.eq} || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL ee_%s got gt/ls/eq=%b%b%b cyc=%0d required %b%b%b cyc=%0d",
                             e.name, gt1, ls1, eq1, cyc, e.gt, e.ls, e.eq, e.cyc);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (done0) begin
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL full_unexpected_done cyc=%0d got gt/ls/eq=%b%b%b required no done", cyc, gt0, ls0, eq0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if ({gt0, ls0, eq0} !== {e.gt, e.ls, e.eq} || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL full_%s got gt/ls/eq=%b%b%b cyc=%0d required %b%b%b cyc=%0d",
                             e.name, gt0, ls0, eq0, cyc, e.gt, e.ls, e.eq, e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input bit full, input string nm, input logic eg, input logic el,
                            input logic ee, input int dcyc);
        exp_t e;
        e.name = nm; e.gt = eg; e.ls = el; e.eq = ee; e.cyc = dcyc;
        if (full) q0.push_back(e);
        else      q1.push_back(e);
    endtask

    task automatic wait_idle(input bit full, input string nm);
        int i;
        i = 0;
        while (((full ? busy0 : busy1) == 1'b1) && i < 20) begin
            @(negedge clk);
            i++;
        end
        if ((full ? busy0 : busy1) == 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout got busy=1 required busy=0 within 20 cycles", nm);
        end
    endtask

    // Launch one compare on the chosen instance; d is the expected number of RUN cycles.
    task automatic run_cmp(input bit full, input string nm, input logic [7:0] av, input logic [7:0] bv,
                           input logic sm, input logic eg, input logic el, input logic ee, input int d);
        @(negedge clk);
        a = av; b = bv; signed_mode = sm;
        if (full) start0 = 1'b1;
        else      start1 = 1'b1;
        push_exp(full, nm, eg, el, ee, cyc + 1 + d);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_idle(full, nm);
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({busy1, done1, gt1, ls1, eq1, busy0, done0, gt0, ls0, eq0} !== 10'b0) begin
            fails++;
            $display("FAIL reset_state got ee=%b%b%b%b%b full=%b%b%b%b%b required all 0",
                     busy1, done1, gt1, ls1, eq1, busy0, done0, gt0, ls0, eq0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic;
        run_cmp(0, "gt_a5_5a", 8'hA5, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        run_cmp(0, "lt_12_13", 8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        run_cmp(0, "signed_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        run_cmp(0, "unsigned_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        run_cmp(0, "signed_fe_ff", 8'hFE, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 4);
        run_cmp(0, "gt_digit3", 8'h38, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    endtask

    task automatic test_no_early_exit;
        run_cmp(1, "gt_a5_5a", 8'hA5, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        run_cmp(1, "lt_first_digit", 8'h40, 8'hBF, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        run_cmp(1, "eq_c3", 8'hC3, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 4);
    endtask

    // Equal operands: busy for exactly NUM_DIGITS cycles; operand changes mid-run must not matter.
    task automatic test_eq_busy;
        int n;
        @(negedge clk);
        a = 8'h3C; b = 8'h3C; signed_mode = 1'b0; start1 = 1'b1;
        push_exp(0, "eq_3c", 1'b0, 1'b0, 1'b1, cyc + 1 + 4);
        @(negedge clk);
        start1 = 1'b0;
        a = 8'hFF; b = 8'h00; signed_mode = 1'b1;
        n = 0;
        while (busy1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL eq_busy_cycles got %0d required 4", n);
        end
    endtask

    task automatic test_start_while_busy;
        @(negedge clk);
        a = 8'h3C; b = 8'h3C; signed_mode = 1'b0; start1 = 1'b1;
        push_exp(0, "ignore_start", 1'b0, 1'b0, 1'b1, cyc + 1 + 4);
        @(negedge clk);
        a = 8'hFF; b = 8'h00;
        @(negedge clk);
        start1 = 1'b0;
        wait_idle(0, "ignore_start");
        repeat (6) @(negedge clk);
        tests++;
        if (busy1 !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start_idle got busy=%b required 0", busy1);
        end
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; signed_mode = 1'b0; start1 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start0 = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy1 !== 1'b1 || eq1 !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre_state got busy=%b eq=%b required busy=1 eq=1", busy1, eq1);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({busy1, done1, gt1, ls1, eq1, busy0, done0, gt0, ls0, eq0} !== 10'b0) begin
            fails++;
            $display("FAIL abort_outputs got ee=%b%b%b%b%b full=%b%b%b%b%b required all 0",
                     busy1, done1, gt1, ls1, eq1, busy0, done0, gt0, ls0, eq0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        tests++;
        if ({busy1, done1, busy0, done0} !== 4'b0) begin
            fails++;
            $display("FAIL abort_quiet got busy/done ee=%b%b full=%b%b required 0000", busy1, done1, busy0, done0);
        end
        run_cmp(0, "after_reset", 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    endtask

    // Start held high: second compare is captured on the edge that ends the done cycle.
    task automatic test_back_to_back;
        int c0;
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; signed_mode = 1'b0; start1 = 1'b1;
        c0 = cyc;
        push_exp(0, "b2b_first", 1'b1, 1'b0, 1'b0, c0 + 2);
        push_exp(0, "b2b_second", 1'b0, 1'b1, 1'b0, c0 + 3 + 4);
        @(negedge clk);
        a = 8'h12; b = 8'h13;
        @(negedge clk);
        tests++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done_cycle got done=%b busy=%b required done=1 busy=0", done1, busy1);
        end
        @(negedge clk);
        start1 = 1'b0;
        tests++;
        if (busy1 !== 1'b1) begin
            fails++;
            $display("FAIL b2b_no_dead_cycle got busy=%b required 1", busy1);
        end
        wait_idle(0, "b2b");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_no_early_exit;
        test_eq_busy;
        test_start_while_busy;
        test_reset_abort;
        test_back_to_back;
        repeat (3) @(negedge clk);
        tests++;
        if (q1.size() != 0 || q0.size() != 0) begin
            fails++;
            $display("FAIL outstanding_results got ee=%0d full=%0d required 0 0", q1.size(), q0.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 2, bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 Parameter EARLY_EXIT, default 1; 1 = finish at first differing digit, 0 = always process all digits.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a compare; sampled only in IDLE.
REQ-007 signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare; captured with operands.
REQ-008 a  input  WIDTH  operand A; captured on the accepting edge.
REQ-009 b  input  WIDTH  operand B; captured on the accepting edge.
REQ-010 busy  output  1  high while a compare is in progress.
REQ-011 done  output  1  one-cycle pulse; gt/ls/eq are valid and new in that cycle.
REQ-012 gt  output  1  registered result, A > B.
REQ-013 ls  output  1  registered result, A < B.
REQ-014 eq  output  1  registered result, A == B.

Function
REQ-015 FSM SHALL have two states: IDLE and RUN; NUM_DIGITS = WIDTH/DIGIT.
REQ-016 IDLE with start=1: capture a, b, signed_mode, load digit counter to NUM_DIGITS, go RUN, set busy=1; start=0 stays IDLE.
REQ-017 Signed mode: the MSB of both captured operands SHALL be inverted at capture, after which the compare is unsigned; unsigned mode stores operands unchanged.
REQ-018 Each RUN edge SHALL compare the top DIGIT bits of both shift registers, MSB-first, then shift both left by DIGIT and decrement the counter.
REQ-019 A first differing digit SHALL latch the decision (A digit greater -> gt, else ls); later digits SHALL NOT change a latched decision.
REQ-020 EARLY_EXIT=1: the edge that finds the first difference SHALL be the deciding edge.
REQ-021 The edge processing the last digit SHALL be the deciding edge if none came earlier; no difference found -> eq.
REQ-022 Deciding edge: write exactly one of gt/ls/eq = 1, others 0; done=1 for one cycle; busy=0; go IDLE.
REQ-023 Latency: capture edge k; deciding edge is k+d, where d = index (1..NUM_DIGITS) of first differing digit, or NUM_DIGITS if EARLY_EXIT=0 or equal.
REQ-024 gt/ls/eq SHALL hold the previous result from capture until the next deciding edge.
REQ-025 start while busy SHALL be ignored; operands and mode are not re-sampled.
REQ-026 start=1 in the done cycle SHALL be accepted (state is IDLE), giving back-to-back operation with no dead cycle.
REQ-027 Changing a/b/signed_mode during RUN SHALL NOT affect the result in progress.

Reset
REQ-028 rst=0 SHALL immediately, without clk, force IDLE, busy=0, done=0, gt=0, ls=0, eq=0, counter and shift registers 0.
REQ-029 Reset during RUN SHALL abort the compare; no done pulse SHALL follow it.
REQ-030 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification (WIDTH=8, DIGIT=2 unless stated)
REQ-031 Unsigned a=0xA5, b=0x5A, start -> done at capture+1, gt=1, ls=0, eq=0.
REQ-032 a=b=0x3C -> done at capture+4, eq=1; busy high for exactly 4 cycles.
REQ-033 a=0x80, b=0x01: signed_mode=1 -> ls=1; signed_mode=0 -> gt=1.
REQ-034 a=0x12, b=0x13 -> done at capture+4, ls=1; EARLY_EXIT=0 with a=0xA5, b=0x5A -> done at capture+4, gt=1.
REQ-035 Reset asserted 2 cycles into a RUN with a=b=0xFF -> all outputs 0 immediately, no done pulse; start pulsed during RUN is ignored.
REQ-036 Back-to-back: start held high through done -> second compare captured in the done cycle, results of both compares correct.
